pll_reset_ctrl: RTL and testbench
=================================

Name: pll_reset_ctrl

Overview:
- Controller on the other side of the PLL interface: drives the PLL reset input and consumes its lock output.
- Sequences the PLL out of reset and qualifies lock for a minimum stable time before releasing the downstream system reset.
- Re-arms automatically on loss of lock or lock timeout.
- Runs on the free-running reference clock (IBUF output, before the PLL), so it keeps operating while the PLL is unlocked.

Parameters:
- RST_CYCLES, 16: cycles pll_reset is held high per attempt (min 1).
- LOCK_TIMEOUT, 65536: cycles to wait for synchronized lock before retrying (min 1).
- STABLE_CYCLES, 1024: consecutive synchronized-lock-high cycles required before release (min 1).
- CNT_W, 8: width of the saturating event counters.

Ports:
- clk_100m  input  1  reference clock, free-running.
- reset  input  1  synchronous, active-high.
- pll_lock  input  1  PLL lock, asynchronous to clk_100m.
- pll_reset  output  1  reset to the PLL.
- sys_reset  output  1  reset to downstream logic; high until lock is qualified.
- pll_ready  output  1  high only in RUN.
- lock_loss_cnt  output  CNT_W  saturating count of lock losses seen in RUN.
- timeout_cnt  output  CNT_W  saturating count of lock timeouts.

Behaviour:
- One clock; reset is synchronous and active-high.
- pll_lock passes through a 2-flop synchronizer (lock_s). The sync flops reset to 0. All decisions use lock_s.
- Synchronizer latency: 2 cycles.
- Reset values: state=PLL_RST, timer=0, pll_reset=1, sys_reset=1, pll_ready=0, both counters=0.
- All outputs are registered.
- State PLL_RST:
  - pll_reset=1, sys_reset=1.
  - Timer counts to RST_CYCLES-1, then goes to WAIT_LOCK with timer cleared.
  - pll_reset stays high for exactly RST_CYCLES cycles after the reset release cycle.
- State WAIT_LOCK:
  - pll_reset=0, sys_reset=1.
  - If lock_s=1: go to STABLE, timer cleared.
  - Else if timer==LOCK_TIMEOUT-1: timeout_cnt++ (saturating), go to PLL_RST.
- State STABLE:
  - pll_reset=0, sys_reset=1.
  - If lock_s=0: go to WAIT_LOCK, timer cleared. No counter change; this is a glitch, not a loss.
  - Else if timer==STABLE_CYCLES-1: go to RUN.
- State RUN:
  - pll_reset=0, sys_reset=0, pll_ready=1.
  - If lock_s=0: lock_loss_cnt++ (saturating), go to PLL_RST, timer cleared.
  - sys_reset and pll_ready take their new values on the same edge as the state change.
- Timer: one shared counter, wide enough for max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES). Cleared on every state change.
- Counters saturate at all-ones and never wrap. They are cleared only by reset.
- Reset mid-operation from any state: returns to PLL_RST next cycle, sys_reset=1 immediately registered, counters cleared.
- Simultaneous events:
  - In WAIT_LOCK, lock_s rising on the timeout cycle: lock wins, go to STABLE, no timeout count.
  - In STABLE, lock_s falling on the final cycle: fall wins, go to WAIT_LOCK.
- Release latency after the pll_lock rise: 2 sync cycles, plus 1 cycle to enter STABLE, plus STABLE_CYCLES.

Decomposition:
- Shared package holds:
  - State enum: PLL_RST, WAIT_LOCK, STABLE, RUN.
  - A function computing the timer width (clog2 of the max of the three cycle parameters).
- One sub-module: sync_2ff, a generic 2-flop bit synchronizer with a reset value parameter. The rest of the codebase reuses it.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, CNT_W=2):
- Clean start: reset for 3 cycles, pll_lock rises 10 cycles after release and stays high -> pll_reset high exactly 4 cycles. sys_reset falls 2+1+8 cycles after the pll_lock rise edge. pll_ready rises on the same edge. Counters stay 0.
- Timeout: pll_lock held 0 -> pll_reset re-pulses for 4 cycles every 24 cycles. timeout_cnt goes 1, 2, 3, then stays 3 (saturation). sys_reset stays 1.
- Glitch during STABLE: lock high for 5 cycles, low for 1, then high -> state returns to WAIT_LOCK. The 8-cycle stable window restarts. lock_loss_cnt stays 0.
- Loss in RUN: drop pll_lock for 1 cycle after pll_ready -> sys_reset=1 and pll_reset=1 on the third edge after the drop. lock_loss_cnt=1. Full re-sequence to RUN follows.
- Reset mid-STABLE with counters nonzero -> next cycle: state PLL_RST, both counters 0, pll_reset=1, sys_reset=1.
- Timeout/lock race: lock_s rises on timer==19 in WAIT_LOCK -> goes to STABLE, timeout_cnt unchanged, no pll_reset pulse.

Source files
------------

// File: rtl/pll_reset_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pll_reset_ctrl_pkg
//
// Shared definitions for the PLL reset controller:
//   - pll_state_e : controller state encoding
//   - timer_width : width of the shared state timer for a given set of
//                   cycle-count parameters
// -----------------------------------------------------------------------------
package pll_reset_ctrl_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,  // holding the PLL in reset
    WAIT_LOCK = 2'd1,  // PLL released, waiting for synchronized lock
    STABLE    = 2'd2,  // lock seen, qualifying it for a minimum time
    RUN       = 2'd3   // lock qualified, downstream reset released
  } pll_state_e;

  // Bits needed to count 0 .. max(a, b, c) - 1. Never returns less than one
  // bit so a degenerate all-ones parameter set still yields a legal vector.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage : pll_reset_ctrl_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//
// Generic two-flop single-bit synchronizer with a configurable reset value.
// Latency from d to q is two clk edges. Intended for level signals only.
//
// Parameters:
//   RESET_VAL : value both flops take while reset is high
//
// Ports:
//   clk   : destination clock
//   reset : synchronous, active-high
//   d     : asynchronous input bit
//   q     : synchronized output bit
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  // First stage may go metastable; only the second stage is consumed.
  logic meta;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours, as real flops do.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule : sync_2ff

// File: rtl/pll_reset_ctrl.sv
// -----------------------------------------------------------------------------
// pll_reset_ctrl
//
// Sequences a PLL out of reset, qualifies its lock output for a minimum stable
// time and only then releases the downstream system reset. Retries on lock
// timeout and re-sequences on loss of lock while running. Clocked by the
// free-running reference clock so it keeps working while the PLL is unlocked.
//
// Parameters:
//   RST_CYCLES    : cycles pll_reset is held high per attempt (>= 1)
//   LOCK_TIMEOUT  : cycles to wait for synchronized lock before retry (>= 1)
//   STABLE_CYCLES : consecutive lock-high cycles required before release (>= 1)
//   CNT_W         : width of the saturating event counters
//
// Ports:
//   clk_100m      : reference clock, free-running
//   reset         : synchronous, active-high
//   pll_lock      : PLL lock, asynchronous to clk_100m
//   pll_reset     : reset to the PLL
//   sys_reset     : reset to downstream logic, high until lock is qualified
//   pll_ready     : high only in RUN
//   lock_loss_cnt : saturating count of lock losses seen in RUN
//   timeout_cnt   : saturating count of lock timeouts
// -----------------------------------------------------------------------------
module pll_reset_ctrl
  import pll_reset_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = 8
) (
  input  logic             clk_100m,
  input  logic             reset,
  input  logic             pll_lock,
  output logic             pll_reset,
  output logic             sys_reset,
  output logic             pll_ready,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  localparam int TIMER_W = timer_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

  // Terminal timer values for each timed state.
  localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  pll_state_e         state;
  logic [TIMER_W-1:0] timer;
  logic               lock_s;

  // ---------------------------------------------------------------------------
  // Lock synchronizer: every decision below uses lock_s, never pll_lock.
  // ---------------------------------------------------------------------------
  sync_2ff #(
    .RESET_VAL (1'b0)
  ) u_lock_sync (
    .clk   (clk_100m),
    .reset (reset),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // ---------------------------------------------------------------------------
  // Controller FSM. Outputs are registered and updated on the same edge as the
  // state change that implies them, so they never lag the state by a cycle.
  // The timer is shared by all timed states and cleared on every transition.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_100m) begin
    if (reset) begin
      state         <= PLL_RST;
      timer         <= '0;
      pll_reset     <= 1'b1;
      sys_reset     <= 1'b1;
      pll_ready     <= 1'b0;
      lock_loss_cnt <= '0;
      timeout_cnt   <= '0;
    end else begin
      case (state)
        PLL_RST: begin
          if (timer == RST_LAST) begin
            state     <= WAIT_LOCK;
            timer     <= '0;
            pll_reset <= 1'b0;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end

        WAIT_LOCK: begin
          // Lock is tested first so a lock arriving on the timeout cycle wins.
          if (lock_s) begin
            state <= STABLE;
            timer <= '0;
          end else if (timer == TIMEOUT_LAST) begin
            state     <= PLL_RST;
            timer     <= '0;
            pll_reset <= 1'b1;
            if (timeout_cnt != CNT_MAX) begin
              timeout_cnt <= timeout_cnt + CNT_W'(1);
            end
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end

        STABLE: begin
          // A drop before qualification is a glitch: restart the wait without
          // counting it and without re-resetting the PLL.
          if (!lock_s) begin
            state <= WAIT_LOCK;
            timer <= '0;
          end else if (timer == STABLE_LAST) begin
            state     <= RUN;
            timer     <= '0;
            sys_reset <= 1'b0;
            pll_ready <= 1'b1;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end

        RUN: begin
          if (!lock_s) begin
            state     <= PLL_RST;
            timer     <= '0;
            pll_reset <= 1'b1;
            sys_reset <= 1'b1;
            pll_ready <= 1'b0;
            if (lock_loss_cnt != CNT_MAX) begin
              lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
            end
          end
        end

        default: begin
          // Unreachable with a 4-value 2-bit encoding; recover safely anyway.
          state     <= PLL_RST;
          timer     <= '0;
          pll_reset <= 1'b1;
          sys_reset <= 1'b1;
          pll_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule : pll_reset_ctrl

// File: tb/tb_pll_reset_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_ctrl
//
// Directed bench for pll_reset_ctrl with RST_CYCLES=4, LOCK_TIMEOUT=20,
// STABLE_CYCLES=8, CNT_W=2. Inputs are driven and outputs sampled 1 ns after
// the rising edge; "edge N" below is the Nth rising edge after a marker.
// -----------------------------------------------------------------------------
module tb_pll_reset_ctrl;
  import pll_reset_ctrl_pkg::*;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int CNT_W         = 2;

  logic             clk_100m = 1'b0;
  logic             reset;
  logic             pll_lock;
  logic             pll_reset;
  logic             sys_reset;
  logic             pll_ready;
  logic [CNT_W-1:0] lock_loss_cnt;
  logic [CNT_W-1:0] timeout_cnt;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int base   = 0;
  int n;

  pll_reset_ctrl #(
    .RST_CYCLES    (RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) dut (
    .clk_100m      (clk_100m),
    .reset         (reset),
    .pll_lock      (pll_lock),
    .pll_reset     (pll_reset),
    .sys_reset     (sys_reset),
    .pll_ready     (pll_ready),
    .lock_loss_cnt (lock_loss_cnt),
    .timeout_cnt   (timeout_cnt)
  );

  always #5 clk_100m = ~clk_100m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int cycles = 1);
    repeat (cycles) begin
      @(posedge clk_100m);
      #1;
      cyc++;
    end
  endtask

  task automatic mark();
    base = cyc;
  endtask

  // Advance until the given edge count relative to the last mark.
  task automatic goto_edge(input int rel);
    while (cyc - base < rel) tick();
  endtask

  task automatic check_state(input string tag, input pll_state_e exp);
    check(tag, 32'(dut.state), 32'(exp));
  endtask

  initial begin
    reset    = 1'b1;
    pll_lock = 1'b0;

    // ---------------- Clean start ----------------
    tick(3);
    check_state("rst_state", PLL_RST);
    check("rst_pll_reset", 32'(pll_reset), 32'd1);
    check("rst_sys_reset", 32'(sys_reset), 32'd1);
    check("rst_pll_ready", 32'(pll_ready), 32'd0);
    check("rst_loss_cnt", 32'(lock_loss_cnt), 32'd0);
    check("rst_timeout_cnt", 32'(timeout_cnt), 32'd0);
    reset = 1'b0;
    mark();

    // pll_reset high for RST_CYCLES samples counted from the release point.
    n = 0;
    while (pll_reset && n < 50) begin
      n++;
      tick();
    end
    check("start_pll_reset_len", 32'(n), 32'd4);

    goto_edge(10);
    pll_lock = 1'b1;
    n = 0;
    while (sys_reset && n < 100) begin
      n++;
      tick();
    end
    check("start_release_latency", 32'(n), 32'd11);
    check("start_pll_ready", 32'(pll_ready), 32'd1);
    check("start_loss_cnt", 32'(lock_loss_cnt), 32'd0);
    check("start_timeout_cnt", 32'(timeout_cnt), 32'd0);

    // ---------------- Loss in RUN ----------------
    pll_lock = 1'b0;
    mark();
    tick();
    pll_lock = 1'b1;
    check("loss_e1_sys_reset", 32'(sys_reset), 32'd0);
    goto_edge(2);
    check("loss_e2_pll_ready", 32'(pll_ready), 32'd1);
    goto_edge(3);
    check("loss_e3_sys_reset", 32'(sys_reset), 32'd1);
    check("loss_e3_pll_reset", 32'(pll_reset), 32'd1);
    check("loss_e3_pll_ready", 32'(pll_ready), 32'd0);
    check("loss_e3_loss_cnt", 32'(lock_loss_cnt), 32'd1);
    // 4 cycles PLL_RST + 1 to see lock + 8 stable.
    n = 0;
    while (sys_reset && n < 100) begin
      n++;
      tick();
    end
    check("loss_resequence_len", 32'(n), 32'd13);
    check("loss_resequence_ready", 32'(pll_ready), 32'd1);
    check("loss_timeout_cnt", 32'(timeout_cnt), 32'd0);

    // ---------------- Reset from RUN, then glitch in STABLE ----------------
    reset    = 1'b1;
    pll_lock = 1'b0;
    tick();
    reset = 1'b0;
    check("rstrun_loss_cnt", 32'(lock_loss_cnt), 32'd0);
    check("rstrun_sys_reset", 32'(sys_reset), 32'd1);
    mark();
    goto_edge(4);
    check_state("glitch_wait", WAIT_LOCK);
    pll_lock = 1'b1;
    goto_edge(9);
    pll_lock = 1'b0;
    goto_edge(10);
    pll_lock = 1'b1;
    goto_edge(11);
    check_state("glitch_e11_stable", STABLE);
    goto_edge(12);
    check_state("glitch_e12_back_wait", WAIT_LOCK);
    goto_edge(13);
    check_state("glitch_e13_stable", STABLE);
    goto_edge(20);
    check("glitch_e20_sys_reset", 32'(sys_reset), 32'd1);
    goto_edge(21);
    check("glitch_e21_sys_reset", 32'(sys_reset), 32'd0);
    check("glitch_loss_cnt", 32'(lock_loss_cnt), 32'd0);

    // ---------------- Timeout and saturation ----------------
    pll_lock = 1'b0;
    mark();
    goto_edge(3);
    check("to_loss_cnt", 32'(lock_loss_cnt), 32'd1);
    goto_edge(7);
    check("to_e7_pll_reset", 32'(pll_reset), 32'd0);
    goto_edge(26);
    check("to_e26_pll_reset", 32'(pll_reset), 32'd0);
    check("to_e26_timeout_cnt", 32'(timeout_cnt), 32'd0);
    goto_edge(27);
    check("to_e27_pll_reset", 32'(pll_reset), 32'd1);
    check("to_e27_timeout_cnt", 32'(timeout_cnt), 32'd1);
    goto_edge(30);
    check("to_e30_pll_reset", 32'(pll_reset), 32'd1);
    goto_edge(31);
    check("to_e31_pll_reset", 32'(pll_reset), 32'd0);
    goto_edge(50);
    check("to_e50_timeout_cnt", 32'(timeout_cnt), 32'd1);
    goto_edge(51);
    check("to_e51_timeout_cnt", 32'(timeout_cnt), 32'd2);
    goto_edge(75);
    check("to_e75_timeout_cnt", 32'(timeout_cnt), 32'd3);
    goto_edge(99);
    check("to_e99_timeout_sat", 32'(timeout_cnt), 32'd3);
    check("to_e99_pll_reset", 32'(pll_reset), 32'd1);
    check("to_e99_sys_reset", 32'(sys_reset), 32'd1);

    // ---------------- Reset mid-STABLE with counters nonzero ----------------
    goto_edge(103);
    pll_lock = 1'b1;
    goto_edge(108);
    check_state("mid_stable_state", STABLE);
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    pll_lock = 1'b0;
    check_state("mid_rst_state", PLL_RST);
    check("mid_rst_loss_cnt", 32'(lock_loss_cnt), 32'd0);
    check("mid_rst_timeout_cnt", 32'(timeout_cnt), 32'd0);
    check("mid_rst_pll_reset", 32'(pll_reset), 32'd1);
    check("mid_rst_sys_reset", 32'(sys_reset), 32'd1);

    // ---------------- Timeout / lock race ----------------
    // WAIT_LOCK from edge 4; timer==19 is evaluated at edge 24. Lock driven
    // after edge 21 makes lock_s first high for that evaluation.
    mark();
    goto_edge(21);
    pll_lock = 1'b1;
    goto_edge(23);
    check_state("race_e23_wait", WAIT_LOCK);
    goto_edge(24);
    check_state("race_e24_stable", STABLE);
    check("race_timeout_cnt", 32'(timeout_cnt), 32'd0);
    check("race_e24_pll_reset", 32'(pll_reset), 32'd0);
    goto_edge(28);
    check("race_e28_pll_reset", 32'(pll_reset), 32'd0);
    goto_edge(31);
    check("race_e31_sys_reset", 32'(sys_reset), 32'd1);
    goto_edge(32);
    check("race_e32_sys_reset", 32'(sys_reset), 32'd0);
    check("race_e32_pll_ready", 32'(pll_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pll_reset_ctrl
